// File: rtl/rv_pkg.sv
// Shared fetch-path types and constants for the fetch/decode boundary.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-side inputs and decode-side outputs of the fetch buffer.
interface fetch_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] PCF_i;
  logic [DATA_WIDTH-1:0] InstrF_i;
  logic                  StallD_i;
  logic                  FlushD_i;
  logic                  PCEn_o;
  logic [DATA_WIDTH-1:0] InstrD_o;
  logic [DATA_WIDTH-1:0] PCD_o;
  logic [DATA_WIDTH-1:0] PCPlus4D_o;
  logic                  ValidD_o;
  logic [CntW-1:0]       Count_o;

  modport slave (
    input  PCF_i, InstrF_i, StallD_i, FlushD_i,
    output PCEn_o, InstrD_o, PCD_o, PCPlus4D_o, ValidD_o, Count_o
  );

  modport master (
    output PCF_i, InstrF_i, StallD_i, FlushD_i,
    input  PCEn_o, InstrD_o, PCD_o, PCPlus4D_o, ValidD_o, Count_o
  );

endinterface

// File: rtl/fifo_ctrl.sv
// Read/write pointers and occupancy count for a power-of-two circular FIFO.
module fifo_ctrl #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            clear_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [PtrW-1:0] rd_ptr_o,
  output logic [PtrW-1:0] wr_ptr_o,
  output logic [CntW-1:0] count_o
);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push_i && !pop_i)      count_d = count_q + CntW'(1);
      else if (pop_i && !push_i) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full_o   = (count_q == CntW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign rd_ptr_o = rd_ptr_q;
  assign wr_ptr_o = wr_ptr_q;
  assign count_o  = count_q;

  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CntW'(DEPTH));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && empty_o && !clear_i));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full_o && !pop_i && !clear_i));

endmodule

// File: rtl/fetch_buffer.sv
// Circular buffer between fetch and decode; freezes the PC when full and
// discards everything on a redirect.
module fetch_buffer
  import rv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned DEPTH      = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  fetch_buffer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic            push, pop, full, empty;
  logic [PtrW-1:0] rd_ptr, wr_ptr;
  logic [CntW-1:0] count;
  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    head, new_entry;

  fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_fifo_ctrl (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (push),
    .pop_i    (pop),
    .clear_i  (bus.FlushD_i),
    .full_o   (full),
    .empty_o  (empty),
    .rd_ptr_o (rd_ptr),
    .wr_ptr_o (wr_ptr),
    .count_o  (count)
  );

  always_comb begin
    pop  = !empty && !bus.StallD_i && !bus.FlushD_i;
    // A full buffer still accepts when the head leaves in the same cycle.
    push = !bus.FlushD_i && (!full || pop);

    new_entry.pc       = bus.PCF_i;
    new_entry.instr    = bus.InstrF_i;
    new_entry.pc_plus4 = bus.PCF_i + DATA_WIDTH'(4);

    head           = mem_q[rd_ptr];
    bus.PCEn_o     = push || bus.FlushD_i;
    bus.ValidD_o   = !empty;
    bus.Count_o    = count;
    bus.InstrD_o   = empty ? NOP_INSTR : head.instr;
    bus.PCD_o      = empty ? '0 : head.pc;
    bus.PCPlus4D_o = empty ? '0 : head.pc_plus4;
  end

  // Storage is left unreset; the valid count masks stale entries.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr] <= new_entry;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Decoupling buffer between the fetch stage (PC register plus combinational instruction memory) and the decode stage.
- Captures {PC, instruction, PC+4} each fetch cycle into a small circular FIFO and presents the head entry to decode.
- Drives the PC register enable so fetch freezes when the buffer is full.
- A branch/jump redirect clears all buffered entries and lets the PC load the redirect target.

Parameters:
- DATA_WIDTH, 32, width of PC and instruction.
- DEPTH, 2, number of buffered entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- PCF_i  in  DATA_WIDTH  current fetch PC from the PC register
- InstrF_i  in  DATA_WIDTH  instruction read combinationally at PCF_i
- StallD_i  in  1  decode cannot accept the head entry this cycle
- FlushD_i  in  1  redirect from execute; discard all buffered and in-flight fetches
- PCEn_o  out  1  enable for the PC register
- InstrD_o  out  DATA_WIDTH  head instruction; NOP_INSTR when buffer empty
- PCD_o  out  DATA_WIDTH  head PC; 0 when empty
- PCPlus4D_o  out  DATA_WIDTH  head PC+4; 0 when empty
- ValidD_o  out  1  head entry is valid
- Count_o  out  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Reset is asynchronous and applies at any time, including mid-operation.
  - Read pointer, write pointer and count go to 0.
  - Outputs under reset: ValidD_o=0, InstrD_o=NOP_INSTR (32'h00000013), PCD_o=0, PCPlus4D_o=0, Count_o=0.
  - Storage array is not reset; its contents are ignored while invalid.
- full = (count==DEPTH); empty = (count==0); ValidD_o = !empty.
- pop = ValidD_o && !StallD_i && !FlushD_i.
- push = !FlushD_i && (!full || pop). Full-and-pop in the same cycle still accepts a new entry.
- PCEn_o = push || FlushD_i. This is combinational.
  - On flush the PC is enabled so the upstream mux loads the redirect target.
  - The instruction fetched at the old PC in that cycle is discarded.
- On push: entry[wr_ptr] <= {PCF_i, InstrF_i, PCF_i+4}, and wr_ptr advances.
  - PC+4 is computed modulo 2^DATA_WIDTH, so 32'hFFFFFFFC yields 0.
- On pop: rd_ptr advances.
- Pointers wrap modulo DEPTH.
- Count update:
  - +1 on push only
  - -1 on pop only
  - unchanged when both push and pop, or neither
- Flush has priority over everything else: next cycle rd_ptr=wr_ptr=count=0 and ValidD_o=0.
- Latency: an instruction fetched in cycle n appears on InstrD_o no earlier than cycle n+1. There is no empty-bypass path.
- Head outputs are driven from registered storage. No combinational path from InstrF_i to InstrD_o.
- Stall while empty has no effect. Stall while full: PCEn_o=0, all state holds, PC freezes.
- Throughput: one instruction per cycle in steady state with no stalls. Count stays at 1.
- Count never exceeds DEPTH and never underflows; the assertions must check both.

Decomposition:
- Shared package rv_pkg holds:
  - NOP_INSTR constant
  - typedef fetch_entry_t struct {pc, instr, pc_plus4}
- Sub-module fifo_ctrl: pointer and count logic with push/pop/clear inputs, and full/empty/rd_ptr/wr_ptr outputs, parameterised by DEPTH.
- fetch_buffer instantiates fifo_ctrl and owns the storage array and the push/pop/enable decode.

Test Plan:
- Reset then free-run; PC=0,4,8 with instructions A,B,C and no stall. ValidD_o rises in cycle 1 with PCD_o=0, InstrD_o=A, PCPlus4D_o=4. Cycles 2 and 3 show 4/B and 8/C. PCEn_o stays 1 and Count_o stays 1.
- Hold StallD_i=1 for 4 cycles from PC=0x10. Count goes 1, then 2. PCEn_o=0 once Count=2, and the PC holds at 0x18. Head stays 0x10. After release, 0x10, 0x14, 0x18 emerge in order with no loss or duplication.
- Full and release in the same cycle: with Count=2 and StallD_i dropped, PCEn_o=1 that cycle. Count stays 2 and the new entry is enqueued.
- FlushD_i=1 with Count=2 and PCF_i=0x20. Next cycle Count_o=0, ValidD_o=0, InstrD_o=0x00000013. PCEn_o=1 during the flush cycle. The target PC=0x100 is pushed the following cycle.
- Wrap-around: PCF_i=0xFFFFFFFC with no stall gives PCPlus4D_o=0. Over 10 push/pop cycles the pointers wrap past DEPTH with correct ordering.
- Assert rst_i asynchronously mid-cycle with Count=2. All outputs go to their reset values immediately, before the next clock edge. After release, normal fetch resumes from PC=0.
